// File: rtl/maroc_sc_serializer_pkg.sv
// Shared types and MAROC3 slow-control frame layout used by the serializer
// and by the upstream frame assembly logic.
package maroc_sc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SC_RST = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FIN    = 3'd4
  } sc_state_e;

  // Bit offsets of the main fields inside the 829-bit MAROC3 SC frame
  localparam int unsigned FRAME_W_MAROC3 = 829;
  localparam int unsigned OFS_DAC2       = 3;
  localparam int unsigned OFS_DAC1       = 13;
  localparam int unsigned OFS_MASK       = 27;
  localparam int unsigned OFS_GAIN       = 189;
  localparam int unsigned OFS_CTEST      = 765;
  localparam int unsigned DAC_W          = 10;

endpackage

// File: rtl/maroc_sc_serializer_if.sv
// Host-side handshake between the configuration register bank and the serializer.
interface maroc_sc_serializer_if #(
  parameter int unsigned FRAME_W = 829
);
  logic               start;
  logic [FRAME_W-1:0] frame;
  logic               busy;
  logic               done;
  logic               rb_err;

  modport master (output start, frame, input busy, done, rb_err);
  modport slave  (input start, frame, output busy, done, rb_err);
endinterface

// File: rtl/maroc_sc_serializer_sc_clk_tick.sv
// Bit-slot divider: one slot is 2*CK_DIV cycles, low phase first, high phase second.
module sc_clk_tick #(
  parameter int unsigned CK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic slot_start_c,
  output logic rise_c,
  output logic sample_c
);
  localparam int unsigned SLOT = 2 * CK_DIV;
  localparam int unsigned CW   = $clog2(SLOT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !en)                  cnt <= '0;
    else if (cnt == CW'(SLOT - 1))   cnt <= '0;
    else                             cnt <= cnt + CW'(1);
  end

  assign slot_start_c = en && (cnt == '0);
  assign rise_c       = en && (cnt == CW'(CK_DIV));
  assign sample_c     = en && (cnt == CW'(SLOT - 1));
endmodule

// File: rtl/maroc_sc_serializer.sv
// MAROC slow-control transmitter: SC reset pulse, serial shift on a divided
// CK_SC and optional second pass that compares the returning Q_SC stream.
module maroc_sc_serializer
  import maroc_sc_pkg::*;
#(
  parameter int unsigned FRAME_W   = 829,
  parameter int unsigned CK_DIV    = 4,
  parameter int unsigned RST_CYC   = 8,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned READBACK  = 1
) (
  input  logic                  CK_in,
  input  logic                  rst,
  maroc_sc_serializer_if.slave  host,
  output logic                  D_SC,
  output logic                  CK_SC,
  output logic                  RSTn_SC,
  input  logic                  Q_SC
);
  localparam int unsigned BCW  = $clog2(FRAME_W + 1);
  localparam int unsigned RCW  = $clog2(RST_CYC + 1);
  localparam int unsigned HEAD = (LSB_FIRST != 0) ? 0 : FRAME_W - 1;

  sc_state_e          state, state_nx;
  logic [BCW-1:0]     bit_cnt;
  logic [RCW-1:0]     rst_cnt;
  logic [FRAME_W-1:0] shift_buf, gold_buf;
  logic               chk_pend;
  logic               slot_start_c, rise_c, sample_c;
  logic               shift_en, last_bit, accept;
  logic               busy_nx, done_nx, rstn_nx;

  sc_clk_tick #(.CK_DIV(CK_DIV)) u_tick (
    .clk          (CK_in),
    .rst          (rst),
    .en           (shift_en),
    .slot_start_c (slot_start_c),
    .rise_c       (rise_c),
    .sample_c     (sample_c)
  );

  // State register
  always_ff @(posedge CK_in) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    last_bit = sample_c && (bit_cnt == BCW'(FRAME_W - 1));
    accept   = (state == ST_IDLE) && host.start;
    unique case (state)
      ST_IDLE:   if (host.start) state_nx = ST_SC_RST;
      ST_SC_RST: if (rst_cnt == RCW'(RST_CYC - 1)) state_nx = ST_SHIFT;
      ST_SHIFT:  if (last_bit) state_nx = (READBACK != 0) ? ST_CHECK : ST_FIN;
      ST_CHECK:  if (last_bit) state_nx = ST_FIN;
      ST_FIN:    state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output decode; every pin is re-timed by one register stage below
  always_comb begin
    busy_nx  = (state_nx != ST_IDLE);
    done_nx  = (state == ST_FIN);
    rstn_nx  = (state != ST_SC_RST);
    shift_en = (state == ST_SHIFT) || (state == ST_CHECK);
  end

  // Datapath and registered outputs
  always_ff @(posedge CK_in) begin
    if (rst) begin
      host.busy   <= 1'b0;
      host.done   <= 1'b0;
      host.rb_err <= 1'b0;
      D_SC        <= 1'b0;
      CK_SC       <= 1'b0;
      RSTn_SC     <= 1'b1;
      rst_cnt     <= '0;
      bit_cnt     <= '0;
      shift_buf   <= '0;
      gold_buf    <= '0;
      chk_pend    <= 1'b0;
    end else begin
      host.busy <= busy_nx;
      host.done <= done_nx;
      RSTn_SC   <= rstn_nx;
      rst_cnt   <= (state == ST_SC_RST) ? rst_cnt + RCW'(1) : '0;

      if (!shift_en) begin
        D_SC    <= 1'b0;
        CK_SC   <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (slot_start_c) begin
          D_SC      <= shift_buf[HEAD];
          shift_buf <= (LSB_FIRST != 0) ? (shift_buf >> 1) : (shift_buf << 1);
          CK_SC     <= 1'b0;
        end
        if (rise_c) CK_SC <= 1'b1;
        if (sample_c) begin
          if (last_bit) begin
            bit_cnt   <= '0;
            shift_buf <= gold_buf;
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
      end

      // D_SC still holds gold bit k during the last high-phase cycle of slot k
      chk_pend <= sample_c && (state == ST_CHECK);
      if (chk_pend && (Q_SC != D_SC)) host.rb_err <= 1'b1;

      if (accept) begin
        shift_buf   <= host.frame;
        gold_buf    <= host.frame;
        host.rb_err <= 1'b0;
      end
    end
  end
endmodule
